// File: rtl/tohost_monitor.sv
// tohost_monitor: passive AXI4 write-channel snoop that watches for stores to
// the tohost word and reports the test outcome (exit, timeout, protocol error).
module tohost_monitor #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 'h8000_1000,
    parameter int                    AW_DEPTH    = 4,
    parameter int                    W_DEPTH     = 8,
    parameter logic [63:0]           MAX_CYCLES  = 64'd0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    aw_valid,
    input  logic                    aw_ready,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]              aw_len,
    input  logic [2:0]              aw_size,
    input  logic [1:0]              aw_burst,
    input  logic                    w_valid,
    input  logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    output logic                    done,
    output logic                    success,
    output logic                    failure,
    output logic [31:0]             exit_code,
    output logic [1:0]              reason,
    output logic [63:0]             cycles
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int AW_PTR     = $clog2(AW_DEPTH);
    localparam int W_PTR      = $clog2(W_DEPTH);
    localparam logic [AW_PTR:0] AW_ONE = 1;
    localparam logic [W_PTR:0]  W_ONE  = 1;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;

    typedef enum logic [1:0] {
        REASON_NONE    = 2'd0,
        REASON_EXIT    = 2'd1,
        REASON_TIMEOUT = 2'd2,
        REASON_ERROR   = 2'd3
    } reason_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } aw_entry_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
    } w_entry_t;

    aw_entry_t aw_mem [AW_DEPTH];
    w_entry_t  w_mem  [W_DEPTH];
    logic [AW_PTR:0] aw_wr_ptr, aw_rd_ptr;
    logic [W_PTR:0]  w_wr_ptr, w_rd_ptr;

    logic aw_fire, w_fire, aw_full, w_full, aw_empty, w_empty;
    logic aw_push, w_push, aw_pop, w_pop, match_valid;
    aw_entry_t aw_head;
    w_entry_t  w_head;

    logic [7:0]            beat_cnt;
    logic [DATA_WIDTH-1:0] shadow;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [DATA_WIDTH-1:0] byte_mask, merged;
    logic [31:0]           exit_val;
    logic hit, proto_err, overflow_err, term_error, term_exit, term_syscall, timeout;
    reason_t reason_q;

    assign aw_fire  = aw_valid & aw_ready;
    assign w_fire   = w_valid & w_ready;
    assign aw_empty = (aw_wr_ptr == aw_rd_ptr);
    assign w_empty  = (w_wr_ptr == w_rd_ptr);
    assign aw_full  = (aw_wr_ptr[AW_PTR] != aw_rd_ptr[AW_PTR]) &&
                      (aw_wr_ptr[AW_PTR-1:0] == aw_rd_ptr[AW_PTR-1:0]);
    assign w_full   = (w_wr_ptr[W_PTR] != w_rd_ptr[W_PTR]) &&
                      (w_wr_ptr[W_PTR-1:0] == w_rd_ptr[W_PTR-1:0]);

    assign aw_head     = aw_mem[aw_rd_ptr[AW_PTR-1:0]];
    assign w_head      = w_mem[w_rd_ptr[W_PTR-1:0]];
    assign match_valid = !aw_empty && !w_empty;
    assign w_pop       = match_valid;
    assign aw_pop      = match_valid && w_head.last;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign aw_push     = aw_fire && (!aw_full || aw_pop);
    assign w_push      = w_fire && (!w_full || w_pop);

    // Snoop FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
        if (aw_push) aw_mem[aw_wr_ptr[AW_PTR-1:0]] <= '{aw_addr, aw_len, aw_size, aw_burst};
        if (w_push)  w_mem[w_wr_ptr[W_PTR-1:0]]    <= '{w_data, w_strb, w_last};
    end

    // FIFO pointers, burst beat counter and the tohost shadow copy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            aw_wr_ptr <= '0;
            aw_rd_ptr <= '0;
            w_wr_ptr  <= '0;
            w_rd_ptr  <= '0;
            beat_cnt  <= '0;
            shadow    <= '0;
        end else begin
            if (aw_push) aw_wr_ptr <= aw_wr_ptr + AW_ONE;
            if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + AW_ONE;
            if (w_push)  w_wr_ptr  <= w_wr_ptr + W_ONE;
            if (w_pop)   w_rd_ptr  <= w_rd_ptr + W_ONE;
            if (aw_pop)      beat_cnt <= '0;
            else if (w_pop)  beat_cnt <= beat_cnt + 8'd1;
            if (hit) shadow <= merged;
        end
    end

    // Match stage: beat address, tohost hit, byte merge and termination events.
    always_comb begin
        beat_addr = aw_head.addr;
        if (aw_head.burst != BURST_FIXED)
            beat_addr = aw_head.addr + (ADDR_WIDTH'(beat_cnt) << aw_head.size);
        for (int i = 0; i < STRB_WIDTH; i++)
            byte_mask[i*8 +: 8] = {8{w_head.strb[i]}};
        merged   = (shadow & ~byte_mask) | (w_head.data & byte_mask);
        exit_val = merged[32:1];
        hit = match_valid &&
              ((aw_head.burst == BURST_FIXED) || (aw_head.burst == BURST_INCR)) &&
              ((beat_addr & ~ADDR_WIDTH'(7)) == TOHOST_ADDR) &&
              (|w_head.strb);
        proto_err = match_valid &&
                    ((aw_head.burst != BURST_FIXED && aw_head.burst != BURST_INCR) ||
                     (w_head.last && beat_cnt != aw_head.len) ||
                     (!w_head.last && beat_cnt == aw_head.len));
        overflow_err = (aw_fire && aw_full && !aw_pop) || (w_fire && w_full && !w_pop);
        term_error   = proto_err || overflow_err;
        term_exit    = hit && merged[0];
        term_syscall = hit && (merged != '0) && !merged[0];
        timeout      = (MAX_CYCLES != 64'd0) && (cycles == MAX_CYCLES - 64'd1);
    end

    // Sticky outcome registers: first event wins, errors outrank exits outrank timeout.
    always_ff @(posedge clock) begin
        if (!reset) begin
            success   <= 1'b0;
            failure   <= 1'b0;
            exit_code <= '0;
            reason_q  <= REASON_NONE;
            cycles    <= '0;
        end else if (!done) begin
            cycles <= cycles + 64'd1;
            if (term_error) begin
                failure  <= 1'b1;
                reason_q <= REASON_ERROR;
            end else if (term_exit) begin
                exit_code <= exit_val;
                success   <= (exit_val == 32'd0);
                failure   <= (exit_val != 32'd0);
                reason_q  <= REASON_EXIT;
            end else if (term_syscall) begin
                failure   <= 1'b1;
                exit_code <= 32'hFFFF_FFFF;
                reason_q  <= REASON_ERROR;
            end else if (timeout) begin
                failure  <= 1'b1;
                reason_q <= REASON_TIMEOUT;
            end
        end
    end

    assign done   = success | failure;
    assign reason = reason_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: scoreboard bench for tohost_monitor (watchdog set to 100 cycles).
module tb_tohost_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len, w_strb;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [63:0] w_data;
    logic        done, success, failure;
    logic [31:0] exit_code;
    logic [1:0]  reason;
    logic [63:0] cycles;

    always #5 clock = ~clock;

    tohost_monitor #(.MAX_CYCLES(64'd100)) dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_strb(w_strb), .w_last(w_last),
        .done(done), .success(success), .failure(failure),
        .exit_code(exit_code), .reason(reason), .cycles(cycles)
    );

    typedef struct packed {
        logic        done;
        logic        success;
        logic        failure;
        logic [31:0] code;
        logic [1:0]  reason;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        aw_valid = 0; aw_ready = 0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        w_valid = 0; w_ready = 0; w_data = '0; w_strb = '0; w_last = 0;
    endtask

    // Hold reset for one edge, confirm every output cleared, then release.
    task automatic applyReset(input string tag);
        idleInputs();
        reset = 1'b0;
        tick();
        checkOutput({tag, "_rst_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_rst_success"}, 64'(success), 64'd0);
        checkOutput({tag, "_rst_failure"}, 64'(failure), 64'd0);
        checkOutput({tag, "_rst_code"}, 64'(exit_code), 64'd0);
        checkOutput({tag, "_rst_reason"}, 64'(reason), 64'd0);
        checkOutput({tag, "_rst_cycles"}, cycles, 64'd0);
        reset = 1'b1;
    endtask

    // Drive one cycle of AW/W channel activity, then return the bus to idle.
    task automatic applyStimulus(input logic awv, input logic awr, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                 input logic wv, input logic wr, input logic [63:0] data,
                                 input logic [7:0] strb, input logic last);
        aw_valid = awv; aw_ready = awr; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        w_valid = wv; w_ready = wr; w_data = data; w_strb = strb; w_last = last;
        tick();
        idleInputs();
    endtask

    function automatic void pushExpected(input logic d, input logic s, input logic f,
                                         input logic [31:0] code, input logic [1:0] rsn, input int lat);
        exp_t e;
        e.done = d; e.success = s; e.failure = f; e.code = code; e.reason = rsn; e.lat = lat;
        sb.push_back(e);
    endfunction

    // Bounded wait for done; lat is the number of edges after the last stimulus edge.
    task automatic waitAndCheck(input string tag, input int budget);
        exp_t e;
        int edges = 0;
        while (done !== 1'b1 && edges < budget) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_sb_has_entry"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_done"}, 64'(done), 64'(e.done));
            checkOutput({tag, "_success"}, 64'(success), 64'(e.success));
            checkOutput({tag, "_failure"}, 64'(failure), 64'(e.failure));
            checkOutput({tag, "_code"}, 64'(exit_code), 64'(e.code));
            checkOutput({tag, "_reason"}, 64'(reason), 64'(e.reason));
            checkOutput({tag, "_latency"}, 64'(edges), 64'(e.lat));
        end
    endtask

    localparam logic [31:0] TH = 32'h8000_1000;

    initial begin
        idleInputs();
        reset = 1'b0;

        applyReset("single");
        pushExpected(1, 1, 0, 32'd0, 2'd1, 1);
        applyStimulus(1, 1, TH, 8'd0, 3'd3, 2'd1, 1, 1, 64'h1, 8'hFF, 1);
        waitAndCheck("single", 10);
        pushExpected(1, 1, 0, 32'd0, 2'd1, 0);
        applyStimulus(1, 1, TH, 8'd0, 3'd3, 2'd1, 1, 1, 64'h7, 8'hFF, 1);
        tick();
        tick();
        waitAndCheck("sticky", 5);
        checkOutput("sticky_cycles", cycles, 64'd2);

        applyReset("early_w");
        pushExpected(1, 0, 1, 32'd3, 2'd1, 1);
        applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 1, 0, 64'h2, 8'hFF, 1);
        applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 1, 1, 64'h7, 8'hFF, 1);
        applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 0, 0, 64'h0, 8'h00, 0);
        applyStimulus(1, 1, TH, 8'd0, 3'd3, 2'd1, 0, 0, 64'h0, 8'h00, 0);
        waitAndCheck("early_w", 10);

        applyReset("burst");
        pushExpected(1, 1, 0, 32'd0, 2'd1, 0);
        applyStimulus(1, 1, 32'h8000_0FF0, 8'd3, 3'd3, 2'd1, 1, 1, 64'hAB00_0000_0000_0010, 8'hFF, 0);
        applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 1, 1, 64'h1234_0000_0000_0020, 8'hFF, 0);
        applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 1, 1, 64'hFFFF_FFFF_0000_0001, 8'h0F, 0);
        applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 1, 1, 64'h0000_0000_0000_0006, 8'hFF, 1);
        waitAndCheck("burst", 10);

        applyReset("split");
        pushExpected(0, 0, 0, 32'd0, 2'd0, 3);
        applyStimulus(1, 1, TH, 8'd0, 3'd3, 2'd1, 1, 1, 64'h0000_0000_0000_00FF, 8'hF0, 1);
        waitAndCheck("split_lo", 3);
        pushExpected(1, 0, 1, 32'd2, 2'd1, 1);
        applyStimulus(1, 1, TH, 8'd0, 3'd3, 2'd1, 1, 1, 64'hFFFF_FFFF_0000_0005, 8'h0F, 1);
        waitAndCheck("split_hi", 10);

        applyReset("syscall");
        pushExpected(1, 0, 1, 32'hFFFF_FFFF, 2'd3, 1);
        applyStimulus(1, 1, TH, 8'd0, 3'd3, 2'd1, 1, 1, 64'h2, 8'hFF, 1);
        waitAndCheck("syscall", 10);

        applyReset("timeout");
        pushExpected(1, 0, 1, 32'd0, 2'd2, 100);
        waitAndCheck("timeout", 150);
        checkOutput("timeout_cycles", cycles, 64'd100);
        tick();
        tick();
        tick();
        checkOutput("timeout_frozen", cycles, 64'd100);

        applyReset("overflow");
        pushExpected(1, 0, 1, 32'd0, 2'd3, 0);
        for (int i = 0; i < 9; i++)
            applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 1, 1, 64'(i + 16), 8'hFF, 1);
        waitAndCheck("overflow", 10);

        applyReset("early_last");
        pushExpected(1, 0, 1, 32'd0, 2'd3, 1);
        applyStimulus(1, 1, 32'h0000_2000, 8'd3, 3'd3, 2'd1, 1, 1, 64'h10, 8'hFF, 0);
        applyStimulus(0, 0, '0, 8'd0, 3'd0, 2'd0, 1, 1, 64'h20, 8'hFF, 1);
        waitAndCheck("early_last", 10);

        applyReset("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
